// File: rtl/tx_rd_req_trigger.sv
// TX host-read trigger: decides when to issue host memory-read requests that pull packets into the TX buffer.
// Define TX_RD_REQ_STATS_EN to build the request/qword statistics counters.
module tx_rd_req_trigger #(
    parameter int unsigned BUF_AW          = 10,
    parameter int unsigned MAX_QW          = 16,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 'h10000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              doorbell_valid,
    input  logic [18:0]       doorbell_qw,
    input  logic [BUF_AW-1:0] buf_commited_rd_addr,
    output logic              rd_req,
    input  logic              rd_req_ack,
    output logic [4:0]        rd_qwords,
    output logic [18:0]       rd_host_offset,
    output logic [BUF_AW-1:0] rd_buf_addr,
    input  logic              cpl_done,
    output logic              change_huge_page,
    input  logic              change_huge_page_ack,
    output logic [31:0]       stat_reqs,
    output logic [31:0]       stat_qwords
);

    localparam logic [18:0] PAGE_QW = 19'h40000;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [2:0] {StIdle, StReq, StUpdate, StHpWait, StHpChg} state_e;

    state_e            state_q;
    logic [18:0]       host_prod_q;
    logic [18:0]       host_cons_q;
    logic [BUF_AW-1:0] buf_wr_ptr_q;
    logic [OW-1:0]     outstanding_q;
    logic [18:0]       pending_q;
    logic [BUF_AW-1:0] free_q;
    logic [TW-1:0]     idle_cnt_q;
    logic              stale_q;

    logic timeout;
    logic can_issue;
    logic full_ok;
    logic short_ok;
    logic upd;

    always_comb begin
        timeout   = (idle_cnt_q == TW'(TIMEOUT_CYCLES));
        can_issue = (outstanding_q < OW'(MAX_OUTSTANDING));
        full_ok   = (32'(pending_q) >= MAX_QW) && (32'(free_q) >= MAX_QW);
        short_ok  = (pending_q != '0) && timeout && (32'(free_q) >= 32'(pending_q));
        upd       = (state_q == StUpdate);
    end

    // pending/free lag host_cons/buf_wr_ptr by one cycle; stale_q blocks decisions on old values
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q     <= '0;
            free_q        <= '0;
            idle_cnt_q    <= '0;
            outstanding_q <= '0;
        end else begin
            pending_q <= host_prod_q - host_cons_q;
            free_q    <= buf_commited_rd_addr - buf_wr_ptr_q - BUF_AW'(1);
            if (state_q != StIdle) begin
                idle_cnt_q <= '0;
            end else if (!timeout) begin
                idle_cnt_q <= idle_cnt_q + TW'(1);
            end
            if (upd && !cpl_done) begin
                outstanding_q <= outstanding_q + OW'(1);
            end else if (!upd && cpl_done && outstanding_q != '0) begin
                outstanding_q <= outstanding_q - OW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= StIdle;
            host_prod_q      <= '0;
            host_cons_q      <= '0;
            buf_wr_ptr_q     <= '0;
            stale_q          <= 1'b0;
            rd_req           <= 1'b0;
            rd_qwords        <= '0;
            rd_host_offset   <= '0;
            rd_buf_addr      <= '0;
            change_huge_page <= 1'b0;
        end else begin
            stale_q <= 1'b0;
            if (doorbell_valid) begin
                host_prod_q <= doorbell_qw;
            end
            unique case (state_q)
                StIdle: begin
                    if (stale_q) begin
                        state_q <= StIdle;
                    end else if (host_cons_q == PAGE_QW) begin
                        state_q <= StHpWait;
                    end else if (can_issue && (full_ok || short_ok)) begin
                        rd_req         <= 1'b1;
                        rd_qwords      <= full_ok ? 5'(MAX_QW) : pending_q[4:0];
                        rd_host_offset <= host_cons_q;
                        rd_buf_addr    <= buf_wr_ptr_q;
                        state_q        <= StReq;
                    end
                end
                StReq: begin
                    if (rd_req_ack) begin
                        rd_req  <= 1'b0;
                        state_q <= StUpdate;
                    end
                end
                StUpdate: begin
                    host_cons_q  <= host_cons_q + 19'(rd_qwords);
                    buf_wr_ptr_q <= buf_wr_ptr_q + BUF_AW'(rd_qwords);
                    stale_q      <= 1'b1;
                    state_q      <= StIdle;
                end
                StHpWait: begin
                    if (outstanding_q == '0) begin
                        change_huge_page <= 1'b1;
                        state_q          <= StHpChg;
                    end
                end
                StHpChg: begin
                    if (change_huge_page_ack) begin
                        change_huge_page <= 1'b0;
                        host_cons_q      <= '0;
                        host_prod_q      <= '0;
                        stale_q          <= 1'b1;
                        state_q          <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef TX_RD_REQ_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_reqs   <= '0;
            stat_qwords <= '0;
        end else if (upd) begin
            stat_reqs   <= stat_reqs + 32'd1;
            stat_qwords <= stat_qwords + 32'(rd_qwords);
        end
    end
`else
    assign stat_reqs   = '0;
    assign stat_qwords = '0;
`endif

endmodule

// File: tb/tb_tx_rd_req_trigger.sv
// Randomised/directed bench for tx_rd_req_trigger; requests are checked against a chunking model
// (MAX_QW chunks, tail on timeout) plus a second instance that walks a whole 2MB page.
module tb_tx_rd_req_trigger;

    localparam int unsigned AW   = 5;
    localparam int unsigned MQ   = 16;
    localparam int unsigned MO   = 4;
    localparam int unsigned TO   = 40;
    localparam int unsigned H_AW = 6;
    localparam int unsigned H_MQ = 31;
    localparam int unsigned PAGE = 32'h40000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic          doorbell_valid, rd_req, rd_req_ack, cpl_done, change_huge_page, change_huge_page_ack;
    logic [18:0]   doorbell_qw, rd_host_offset;
    logic [AW-1:0] buf_commited_rd_addr, rd_buf_addr;
    logic [4:0]    rd_qwords;
    logic [31:0]   stat_reqs, stat_qwords;

    logic            h_doorbell_valid, h_rd_req, h_rd_req_ack, h_cpl_done, h_change_huge_page;
    logic            h_change_huge_page_ack;
    logic [18:0]     h_doorbell_qw, h_rd_host_offset;
    logic [H_AW-1:0] h_buf_commited_rd_addr, h_rd_buf_addr;
    logic [4:0]      h_rd_qwords;
    logic [31:0]     h_stat_reqs, h_stat_qwords;

    tx_rd_req_trigger #(.BUF_AW(AW), .MAX_QW(MQ), .MAX_OUTSTANDING(MO), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n), .doorbell_valid(doorbell_valid), .doorbell_qw(doorbell_qw),
        .buf_commited_rd_addr(buf_commited_rd_addr), .rd_req(rd_req), .rd_req_ack(rd_req_ack),
        .rd_qwords(rd_qwords), .rd_host_offset(rd_host_offset), .rd_buf_addr(rd_buf_addr),
        .cpl_done(cpl_done), .change_huge_page(change_huge_page),
        .change_huge_page_ack(change_huge_page_ack), .stat_reqs(stat_reqs),
        .stat_qwords(stat_qwords)
    );

    tx_rd_req_trigger #(.BUF_AW(H_AW), .MAX_QW(H_MQ), .MAX_OUTSTANDING(MO), .TIMEOUT_CYCLES(TO)) dut_hp (
        .clk(clk), .reset_n(reset_n), .doorbell_valid(h_doorbell_valid), .doorbell_qw(h_doorbell_qw),
        .buf_commited_rd_addr(h_buf_commited_rd_addr), .rd_req(h_rd_req), .rd_req_ack(h_rd_req_ack),
        .rd_qwords(h_rd_qwords), .rd_host_offset(h_rd_host_offset), .rd_buf_addr(h_rd_buf_addr),
        .cpl_done(h_cpl_done), .change_huge_page(h_change_huge_page),
        .change_huge_page_ack(h_change_huge_page_ack), .stat_reqs(h_stat_reqs),
        .stat_qwords(h_stat_qwords)
    );

    typedef struct {
        int unsigned qw;
        int unsigned off;
        int unsigned addr;
    } req_t;

    req_t        exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int unsigned prod_m, gen_cons, gen_addr, cons_m, wr_m, inflight, reqs_seen, stat_r, stat_w;
    int unsigned cur_qw, ack_pct, cpl_pct;
    int          coincide_left;
    bit          req_seen, ack_en, cpl_en, consume_en, cpl_next;

    task automatic check_eq(input string tag, input longint unsigned got, input longint unsigned exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        req_t e;
        @(posedge clk);
        #1;
        doorbell_valid = 1'b0;
        rd_req_ack = 1'b0;
        cpl_done = 1'b0;
        change_huge_page_ack = 1'b0;
        if (cpl_next) begin
            cpl_done = 1'b1;
            inflight--;
            cpl_next = 1'b0;
        end
        if (rd_req) begin
            if (!req_seen) begin
                req_seen = 1'b1;
                reqs_seen++;
                check_eq("outstanding_cap", (inflight >= MO) ? 1 : 0, 0);
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_req_qw", rd_qwords, 0);
                    cur_qw = rd_qwords;
                end else begin
                    e = exp_q.pop_front();
                    cur_qw = e.qw;
                    check_eq("req_qwords", rd_qwords, e.qw);
                    check_eq("req_host_offset", rd_host_offset, e.off);
                    check_eq("req_buf_addr", rd_buf_addr, e.addr);
                end
            end
            if (ack_en && $urandom_range(99) < ack_pct) begin
                rd_req_ack = 1'b1;
                req_seen = 1'b0;
                inflight++;
                cons_m += cur_qw;
                wr_m = (wr_m + cur_qw) % (1 << AW);
                stat_r++;
                stat_w += cur_qw;
                if (coincide_left > 0) begin
                    cpl_next = 1'b1;
                    coincide_left--;
                end
            end
        end
        if (!rd_req_ack && !cpl_done && cpl_en && inflight > 0 && $urandom_range(99) < cpl_pct) begin
            cpl_done = 1'b1;
            inflight--;
        end
        if (consume_en) buf_commited_rd_addr = AW'(wr_m);
    endtask

    task automatic ring(input int unsigned prod);
        req_t e;
        doorbell_valid = 1'b1;
        doorbell_qw = 19'(prod);
        prod_m = prod;
        while (gen_cons < prod) begin
            e.qw = (prod - gen_cons >= MQ) ? MQ : prod - gen_cons;
            e.off = gen_cons;
            e.addr = gen_addr;
            exp_q.push_back(e);
            gen_cons += e.qw;
            gen_addr = (gen_addr + e.qw) % (1 << AW);
        end
        tick();
    endtask

    task automatic wait_reqs(input int unsigned n, input int bound);
        for (int i = 0; i < bound && reqs_seen < n; i++) tick();
        check_eq("wait_reqs", reqs_seen, n);
    endtask

    task automatic drain(input int bound);
        for (int i = 0; i < bound && !(cons_m == prod_m && inflight == 0 && !rd_req); i++) tick();
        check_eq("drain_cons", cons_m, prod_m);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        doorbell_valid = 1'b0; doorbell_qw = '0; buf_commited_rd_addr = '0;
        rd_req_ack = 1'b0; cpl_done = 1'b0; change_huge_page_ack = 1'b0;
        exp_q.delete();
        prod_m = 0; gen_cons = 0; gen_addr = 0; cons_m = 0; wr_m = 0; inflight = 0;
        reqs_seen = 0; stat_r = 0; stat_w = 0; cur_qw = 0; coincide_left = 0;
        req_seen = 0; cpl_next = 0;
        ack_en = 1; cpl_en = 1; consume_en = 1; ack_pct = 100; cpl_pct = 100;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic hp_cycle(inout int unsigned seen);
        @(posedge clk);
        #1;
        h_doorbell_valid = 1'b0; h_rd_req_ack = 1'b0; h_cpl_done = 1'b0; h_change_huge_page_ack = 1'b0;
        if (h_change_huge_page) seen++;
    endtask

    task automatic hp_test();
        int unsigned cons = 0, wr = 0, infl = 0, nreq = 0, errs = 0, seen = 0, eq;
        int lat;
        h_doorbell_valid = 1'b1;
        h_doorbell_qw = 19'(PAGE);
        for (int cyc = 0; cyc < 60000; cyc++) begin
            hp_cycle(seen);
            if (cons == PAGE && infl == 2) break;
            if (h_rd_req) begin
                eq = (PAGE - cons < H_MQ) ? PAGE - cons : H_MQ;
                if (h_rd_qwords != 5'(eq) || h_rd_host_offset != 19'(cons) || h_rd_buf_addr != H_AW'(wr))
                    errs++;
                h_rd_req_ack = 1'b1;
                nreq++; infl++; cons += eq;
                wr = (wr + eq) % (1 << H_AW);
                h_buf_commited_rd_addr = H_AW'(wr);
            end else if (infl >= 3) begin
                h_cpl_done = 1'b1;
                infl--;
            end
        end
        check_eq("hp_stream_errs", errs, 0);
        check_eq("hp_req_count", nreq, 8457);
        check_eq("hp_cons_end", cons, PAGE);
        repeat (30) hp_cycle(seen);
        check_eq("hp_wait_two_outstanding", seen, 0);
        h_cpl_done = 1'b1;
        repeat (30) hp_cycle(seen);
        check_eq("hp_wait_one_outstanding", seen, 0);
        h_cpl_done = 1'b1;
        for (int i = 0; i < 10 && !h_change_huge_page; i++) hp_cycle(seen);
        check_eq("hp_change_asserted", h_change_huge_page, 1);
        repeat (5) hp_cycle(seen);
        check_eq("hp_change_held", h_change_huge_page, 1);
        h_change_huge_page_ack = 1'b1;
        hp_cycle(seen);
        check_eq("hp_change_cleared", h_change_huge_page, 0);
        h_doorbell_valid = 1'b1;
        h_doorbell_qw = 19'd20;
        lat = 0;
        do begin
            hp_cycle(seen);
            lat++;
        end while (!h_rd_req && lat < 200);
        check_eq("hp_new_page_req", h_rd_req, 1);
        check_eq("hp_new_page_offset", h_rd_host_offset, 0);
        check_eq("hp_new_page_qwords", h_rd_qwords, 20);
        check_eq("hp_new_page_buf_addr", h_rd_buf_addr, wr);
    endtask

    initial begin
        int lat;
        h_doorbell_valid = 1'b0; h_doorbell_qw = '0; h_buf_commited_rd_addr = '0;
        h_rd_req_ack = 1'b0; h_cpl_done = 1'b0; h_change_huge_page_ack = 1'b0;
        do_reset();
        check_eq("rst_rd_req", rd_req, 0);
        check_eq("rst_rd_qwords", rd_qwords, 0);
        check_eq("rst_rd_host_offset", rd_host_offset, 0);
        check_eq("rst_rd_buf_addr", rd_buf_addr, 0);
        check_eq("rst_change_huge_page", change_huge_page, 0);
        check_eq("rst_stat_reqs", stat_reqs, 0);
        check_eq("rst_stat_qwords", stat_qwords, 0);

        // Five full chunks pending but no completions: only MO may be in flight
        cpl_en = 0;
        ring(80);
        wait_reqs(4, 200);
        repeat (100) tick();
        check_eq("cap_hold", reqs_seen, 4);
        cpl_en = 1;
        wait_reqs(5, 200);
        drain(500);

        // Short tail waits for the idle timeout counted from reset release
        do_reset();
        ring(5);
        lat = 1;
        while (!rd_req && lat < int'(TO) + 20) begin
            tick();
            lat++;
        end
        check_eq("timeout_window", (lat >= int'(TO) && lat <= int'(TO) + 4) ? 1 : 0, 1);
        drain(200);

        // Buffer full: 31-qw buffer holds one 16-qw chunk until the MAC consumes
        do_reset();
        consume_en = 0;
        ring(64);
        wait_reqs(1, 100);
        repeat (100) tick();
        check_eq("buf_full_stall", reqs_seen, 1);
        buf_commited_rd_addr = AW'(16);
        wait_reqs(2, 100);
        repeat (50) tick();
        check_eq("buf_full_stall2", reqs_seen, 2);
        consume_en = 1;
        drain(1000);

        // Completion coinciding with UPDATE leaves the outstanding count unchanged
        do_reset();
        cpl_en = 0;
        ring(96);
        wait_reqs(3, 200);
        coincide_left = 1;
        wait_reqs(5, 200);
        repeat (100) tick();
        check_eq("coincide_cap", reqs_seen, 5);
        cpl_en = 1;
        drain(1000);

        // Async reset while a request is pending
        do_reset();
        ring(32);
        wait_reqs(1, 100);
        ack_en = 0;
        wait_reqs(2, 100);
        tick();
        reset_n = 1'b0;
        #1;
        check_eq("rst_mid_rd_req", rd_req, 0);
        check_eq("rst_mid_rd_qwords", rd_qwords, 0);
        check_eq("rst_mid_rd_host_offset", rd_host_offset, 0);
        check_eq("rst_mid_rd_buf_addr", rd_buf_addr, 0);
        check_eq("rst_mid_change_huge_page", change_huge_page, 0);

        // Random doorbell increments with random ack/completion latency
        do_reset();
        ack_pct = 60;
        cpl_pct = 40;
        for (int r = 0; r < 20; r++) begin
            ring(prod_m + $urandom_range(70, 1));
            drain(3000);
        end
`ifdef TX_RD_REQ_STATS_EN
        check_eq("stat_reqs", stat_reqs, stat_r);
        check_eq("stat_qwords", stat_qwords, stat_w);
`else
        check_eq("stat_reqs_off", stat_reqs, 0);
        check_eq("stat_qwords_off", stat_qwords, 0);
`endif

        hp_test();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
